// File: rtl/srl_fifo32x9_pkg.sv
// Shared constants for SRL-based buffers, plus a small occupancy helper.
package srl_fifo32x9_pkg;

    localparam int SRL_DEPTH = 32;
    localparam int WORD_W    = 9;
    localparam int ADDR_W    = 5;
    localparam int CNT_W     = 6;

    // Total words held: words inside the SRL plus the one parked in the output register.
    function automatic logic [CNT_W-1:0] level_of(input logic [CNT_W-1:0] cnt,
                                                   input logic             held);
        return cnt + {{(CNT_W-1){1'b0}}, held};
    endfunction

endpackage

// File: rtl/srl32x9e.sv
// 32-deep x 9-bit addressable shift register with clock enable.
// New words enter position 0; y is a combinational read of position a (pre-shift).
// Storage is intentionally not reset: the owner gates it with its own occupancy count.
module srl32x9e
    import srl_fifo32x9_pkg::*;
(
    input  logic              clk,
    input  logic              ce,
    input  logic [ADDR_W-1:0] a,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] y
);

    logic [WORD_W-1:0] sr_r [SRL_DEPTH];

    // Shift chain: on ce every word moves one place deeper and d lands at position 0.
    always_ff @(posedge clk) begin
        if (ce) begin
            sr_r[0] <= d;
            for (int i = 1; i < SRL_DEPTH; i++) begin
                sr_r[i] <= sr_r[i-1];
            end
        end
    end

    assign y = sr_r[a];

endmodule

// File: rtl/srl_fifo32x9.sv
// 33-word x 9-bit FIFO: 32 words in an SRL plus one registered output word.
// An occupancy counter drives the SRL shift enable and read address; the oldest
// word is moved into a valid/ready output register whenever that register is free.
module srl_fifo32x9
    import srl_fifo32x9_pkg::*;
#(
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [CNT_W-1:0]  level,
    output logic              almost_full,
    output logic              almost_empty
);

    localparam logic [CNT_W-1:0] AF_THR   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_THR   = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SRL_DEPTH);

    logic [CNT_W-1:0]  srl_cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [WORD_W-1:0] dout_r;
    logic              dout_valid_r;
    logic              din_ready_s;
    logic              push_s;
    logic              ld_s;
    logic [ADDR_W-1:0] addr_s;
    logic [WORD_W-1:0] srl_y_s;
    logic [CNT_W-1:0]  level_s;

    // Handshake decodes come from registers only, so din_ready never depends on dout_ready.
    assign din_ready_s = (srl_cnt_r != CNT_FULL);
    assign push_s      = din_valid & din_ready_s;
    assign ld_s        = (srl_cnt_r != {CNT_W{1'b0}}) & (~dout_valid_r | dout_ready);

    // Read address points at the oldest SRL word; parked at 0 when the SRL is empty.
    always_comb begin
        addr_s = {ADDR_W{1'b0}};
        if (srl_cnt_r != {CNT_W{1'b0}}) begin
            addr_s = srl_cnt_r[ADDR_W-1:0] - {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            addr_s = {ADDR_W{1'b0}};
        end
    end

    // Occupancy update: push and load together leave the count unchanged.
    always_comb begin
        cnt_nxt_s = srl_cnt_r;
        case ({push_s, ld_s})
            2'b10:   cnt_nxt_s = srl_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   cnt_nxt_s = srl_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            default: cnt_nxt_s = srl_cnt_r;
        endcase
    end

    srl32x9e u_srl (
        .clk (clk),
        .ce  (push_s),
        .a   (addr_s),
        .d   (din),
        .y   (srl_y_s)
    );

    // Counter and output register; dout keeps its last value once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            srl_cnt_r    <= {CNT_W{1'b0}};
            dout_r       <= {WORD_W{1'b0}};
            dout_valid_r <= 1'b0;
        end else begin
            srl_cnt_r <= cnt_nxt_s;
            if (ld_s) begin
                dout_r       <= srl_y_s;
                dout_valid_r <= 1'b1;
            end else if (dout_ready & dout_valid_r) begin
                dout_valid_r <= 1'b0;
            end
        end
    end

    assign level_s      = level_of(srl_cnt_r, dout_valid_r);
    assign level        = level_s;
    assign almost_full  = (level_s >= AF_THR);
    assign almost_empty = (level_s <= AE_THR);
    assign din_ready    = din_ready_s;
    assign dout         = dout_r;
    assign dout_valid   = dout_valid_r;

endmodule

// File: tb/tb_srl_fifo32x9.sv
// Directed self-checking bench for srl_fifo32x9.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_srl_fifo32x9;

    logic       clk;
    logic       rst;
    logic [8:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [8:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [5:0] level;
    logic       almost_full;
    logic       almost_empty;

    int errors = 0;
    int checks = 0;

    srl_fifo32x9 #(.AF_LEVEL(28), .AE_LEVEL(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_dv"},   32'(dout_valid),   32'd0);
        check({tag, "_lvl"},  32'(level),        32'd0);
        check({tag, "_rdy"},  32'(din_ready),    32'd1);
        check({tag, "_ae"},   32'(almost_empty), 32'd1);
        check({tag, "_af"},   32'(almost_full),  32'd0);
    endtask

    initial begin
        logic [8:0] exp_w;

        rst        = 1'b1;
        din        = 9'd0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;

        // 1: reset then idle
        #1;
        check_idle("rst");
        check("rst_dout", 32'(dout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle("idle");

        // 2: write 33 words with no consumer
        for (int k = 1; k <= 33; k++) begin
            din       = 9'(k);
            din_valid = 1'b1;
            @(negedge clk);
            if (k == 20) check("fill20_lvl", 32'(level), 32'd20);
        end
        check("full_lvl", 32'(level),       32'd33);
        check("full_rdy", 32'(din_ready),   32'd0);
        check("full_af",  32'(almost_full), 32'd1);
        din = 9'h1FF;
        repeat (3) @(negedge clk);
        check("hold_lvl",  32'(level),      32'd33);
        check("hold_rdy",  32'(din_ready),  32'd0);
        check("hold_dout", 32'(dout),       32'h001);
        check("hold_dv",   32'(dout_valid), 32'd1);

        // 3: drain in order
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            check($sformatf("drain_dv%0d", k), 32'(dout_valid), 32'd1);
            check($sformatf("drain_d%0d", k),  32'(dout),       32'(k));
            @(negedge clk);
        end
        check_idle("drained");

        // 4: single write, latency
        din       = 9'h155;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        check("lat_n_dv",  32'(dout_valid), 32'd0);
        check("lat_n_lvl", 32'(level),      32'd1);
        @(negedge clk);
        check("lat_n1_dv", 32'(dout_valid), 32'd1);
        check("lat_n1_d",  32'(dout),       32'h155);
        @(negedge clk);
        check_idle("lat_done");

        // 5: streaming ramp, concurrent push and pop
        for (int t = 0; t <= 100; t++) begin
            if (t < 100) begin
                din       = 9'(t * 3 + 7);
                din_valid = 1'b1;
            end else begin
                din_valid = 1'b0;
            end
            @(negedge clk);
            check($sformatf("strm_lvl%0d", t), 32'(level <= 6'd2), 32'd1);
            if (t >= 1) begin
                exp_w = 9'((t - 1) * 3 + 7);
                check($sformatf("strm_dv%0d", t), 32'(dout_valid), 32'd1);
                check($sformatf("strm_d%0d", t),  32'(dout),       32'(exp_w));
            end else begin
                check("strm_dv0", 32'(dout_valid), 32'd0);
            end
        end
        @(negedge clk);
        check_idle("strm_done");

        // 6: reset mid-burst
        dout_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            din       = 9'(12'h100 + k);
            din_valid = 1'b1;
            @(negedge clk);
        end
        check("pre_rst_lvl", 32'(level), 32'd20);
        rst       = 1'b1;
        din_valid = 1'b0;
        #1;
        check_idle("midrst");
        check("midrst_dout", 32'(dout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        din       = 9'h0AA;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        check("post_n_dv",   32'(dout_valid), 32'd0);
        check("post_n_lvl",  32'(level),      32'd1);
        check("post_n_dout", 32'(dout),       32'd0);
        @(negedge clk);
        check("post_n1_dv", 32'(dout_valid), 32'd1);
        check("post_n1_d",  32'(dout),       32'h0AA);
        check("post_n1_lv", 32'(level),      32'd1);
        dout_ready = 1'b1;
        @(negedge clk);
        check_idle("post_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
